counter_multi: RTL and testbench

- Parametrised N-channel programmable timer/counter for the MIO peripheral space.
- Successor to the fixed three-channel counter. Adds per-channel modes (one-shot, periodic, square wave, free-run up), a configurable width and channel count, interrupt enables, and sticky pending flags.
- The CPU writes reload values and control words through the bus write strobe. Each channel counts rising edges of its own tick input, normally taken from clock-divider taps.

---
 rtl/counter_multi.sv | 181 ++++++++++++++++++
 tb/tb_counter_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_multi.sv
// N-channel programmable timer/counter: one-shot, periodic, square-wave and
// free-running modes per channel, with sticky pending flags and a shared IRQ.
module counter_multi #(
   parameter int NCH   = 4,
   parameter int WIDTH = 32,
   parameter int CHW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   tick,
   input  logic             counter_we,
   input  logic [CHW-1:0]   counter_ch,
   input  logic             counter_reg,
   input  logic [WIDTH-1:0] counter_val,
   input  logic [CHW-1:0]   rd_ch,
   output logic [WIDTH-1:0] counter_out,
   output logic [NCH-1:0]   counter_OUT,
   output logic [NCH-1:0]   irq_pending,
   output logic             irq
);

   typedef enum logic [1:0] {
      MODE_ONESHOT  = 2'b00,
      MODE_PERIODIC = 2'b01,
      MODE_SQUARE   = 2'b10,
      MODE_FREERUN  = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic [NCH-1:0][WIDTH-1:0] count_q, count_d;
   logic [NCH-1:0][WIDTH-1:0] reload_q, reload_d;
   logic [NCH-1:0][1:0]       mode_q, mode_d;
   logic [NCH-1:0]            en_q, en_d;
   logic [NCH-1:0]            ie_q, ie_d;
   logic [NCH-1:0]            out_q, out_d;
   logic [NCH-1:0]            pend_q, pend_d;
   logic [NCH-1:0]            tick_q, tick_d;
   logic [NCH-1:0]            tick_rise;
   logic [NCH-1:0]            wr_hit;

   logic       ctl_en;
   logic       ctl_ie;
   logic       ctl_clr;
   logic [1:0] ctl_mode;

   assign ctl_en    = counter_val[0];
   assign ctl_mode  = counter_val[2:1];
   assign ctl_ie    = counter_val[3];
   assign ctl_clr   = counter_val[4];
   assign tick_d    = tick;
   assign tick_rise = tick & ~tick_q;

   // Channel numbers at or above NCH match no bit, so such writes are dropped.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NCH; i++) begin
         wr_hit[i] = counter_we && (counter_ch == CHW'(i));
      end
   end

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path leaves it
      // unassigned and no latch can be inferred.
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      en_d     = en_q;
      ie_d     = ie_q;
      out_d    = out_q;
      pend_d   = pend_q;

      for (int i = 0; i < NCH; i++) begin
         if (mode_e'(mode_q[i]) == MODE_PERIODIC || mode_e'(mode_q[i]) == MODE_FREERUN) begin
            out_d[i] = 1'b0;
         end

         // CLR is applied before the count logic so a same-clk event set wins.
         if (wr_hit[i] && counter_reg && ctl_clr) begin
            pend_d[i] = 1'b0;
         end

         if (wr_hit[i] && !counter_reg) begin
            reload_d[i] = counter_val;
            count_d[i]  = counter_val;
            out_d[i]    = 1'b0;
         end else if (tick_rise[i] && en_q[i]) begin
            case (mode_e'(mode_q[i]))
               MODE_ONESHOT: begin
                  if (count_q[i] > ONE) begin
                     count_d[i] = count_q[i] - ONE;
                  end else if (count_q[i] == ONE) begin
                     count_d[i] = ZERO;
                     out_d[i]   = 1'b1;
                     pend_d[i]  = 1'b1;
                     en_d[i]    = 1'b0;
                  end
               end
               MODE_PERIODIC: begin
                  if (count_q[i] > ONE) begin
                     count_d[i] = count_q[i] - ONE;
                  end else if (count_q[i] == ONE) begin
                     count_d[i] = reload_q[i];
                     out_d[i]   = 1'b1;
                     pend_d[i]  = 1'b1;
                  end
               end
               MODE_SQUARE: begin
                  if (count_q[i] > ONE) begin
                     count_d[i] = count_q[i] - ONE;
                  end else if (reload_q[i] != ZERO) begin
                     count_d[i] = reload_q[i];
                     out_d[i]   = ~out_q[i];
                     if (!out_q[i]) begin
                        pend_d[i] = 1'b1;
                     end
                  end
               end
               MODE_FREERUN: begin
                  count_d[i] = count_q[i] + ONE;
                  if (count_q[i] == ONES) begin
                     out_d[i]  = 1'b1;
                     pend_d[i] = 1'b1;
                  end
               end
            endcase
         end

         // Control fields override the edge result (e.g. a one-shot's EN clear).
         if (wr_hit[i] && counter_reg) begin
            en_d[i]   = ctl_en;
            ie_d[i]   = ctl_ie;
            mode_d[i] = ctl_mode;
            if (ctl_mode != mode_q[i]) begin
               out_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the register file is small and software-visible, so every
      // entry is reset rather than left undefined.
      if (rst) begin
         count_q  <= '0;
         reload_q <= '0;
         mode_q   <= '0;
         en_q     <= '0;
         ie_q     <= '0;
         out_q    <= '0;
         pend_q   <= '0;
         tick_q   <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         en_q     <= en_d;
         ie_q     <= ie_d;
         out_q    <= out_d;
         pend_q   <= pend_d;
         tick_q   <= tick_d;
      end
   end

   always_comb begin
      counter_out = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rd_ch == CHW'(i)) begin
            counter_out = count_q[i];
         end
      end
   end

   assign counter_OUT = out_q;
   assign irq_pending = pend_q;
   assign irq         = |(pend_q & ie_q);

endmodule

// File: tb/tb_counter_multi.sv
// Directed bench for counter_multi: stimulus queues expected readbacks,
// a monitor on the falling clock edge pops and compares them.
module tb_counter_multi;

   localparam int NCH   = 4;
   localparam int WIDTH = 32;
   localparam int CHW   = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   tick = '0;
   logic             counter_we = 1'b0;
   logic [CHW-1:0]   counter_ch = '0;
   logic             counter_reg = 1'b0;
   logic [WIDTH-1:0] counter_val = '0;
   logic [CHW-1:0]   rd_ch = '0;
   logic [WIDTH-1:0] counter_out;
   logic [NCH-1:0]   counter_OUT;
   logic [NCH-1:0]   irq_pending;
   logic             irq;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] cnt;
      logic [NCH-1:0]   out;
      logic [NCH-1:0]   pend;
      logic             irq;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   counter_multi #(.NCH(NCH), .WIDTH(WIDTH), .CHW(CHW)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .counter_we  (counter_we),
      .counter_ch  (counter_ch),
      .counter_reg (counter_reg),
      .counter_val (counter_val),
      .rd_ch       (rd_ch),
      .counter_out (counter_out),
      .counter_OUT (counter_OUT),
      .irq_pending (irq_pending),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from state updates.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, ".count"}, counter_out, e.cnt);
            check({e.name, ".out"}, WIDTH'(counter_OUT), WIDTH'(e.out));
            check({e.name, ".pend"}, WIDTH'(irq_pending), WIDTH'(e.pend));
            check({e.name, ".irq"}, WIDTH'(irq), WIDTH'(e.irq));
         end
      end
   end

   task automatic chk(input string name, input int ch, input logic [WIDTH-1:0] cnt,
                      input logic [NCH-1:0] out, input logic [NCH-1:0] pend, input logic irq_e);
      exp_t e;
      rd_ch  = CHW'(ch);
      e.name = name;
      e.cnt  = cnt;
      e.out  = out;
      e.pend = pend;
      e.irq  = irq_e;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic bus_wr(input int ch, input logic reg_sel, input logic [WIDTH-1:0] val);
      counter_we  = 1'b1;
      counter_ch  = CHW'(ch);
      counter_reg = reg_sel;
      counter_val = val;
      @(posedge clk); #1;
      counter_we  = 1'b0;
   endtask

   // Rising tick level; the edge is acted on at the next clk edge.
   task automatic tick_edge(input logic [NCH-1:0] m);
      tick = tick | m;
      @(posedge clk); #1;
      tick = tick & ~m;
   endtask

   task automatic bus_wr_edge(input int ch, input logic reg_sel, input logic [WIDTH-1:0] val,
                              input logic [NCH-1:0] m);
      tick        = tick | m;
      counter_we  = 1'b1;
      counter_ch  = CHW'(ch);
      counter_reg = reg_sel;
      counter_val = val;
      @(posedge clk); #1;
      counter_we  = 1'b0;
      tick        = tick & ~m;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state and out-of-range writes/reads
      for (int c = 0; c < NCH; c++) chk($sformatf("rst_ch%0d", c), c, 0, 4'b0000, 4'b0000, 1'b0);
      bus_wr(5, 1'b0, 32'h0000_1234);
      bus_wr(5, 1'b1, 32'h0000_000F);
      tick_edge(4'b1111);
      for (int c = 0; c < NCH; c++) chk($sformatf("oor_ch%0d", c), c, 0, 4'b0000, 4'b0000, 1'b0);
      chk("oor_rd5", 5, 0, 4'b0000, 4'b0000, 1'b0);

      // One-shot on ch0
      do_reset();
      bus_wr(0, 1'b0, 3);
      bus_wr(0, 1'b1, 32'h09);
      chk("os_load", 0, 3, 4'b0000, 4'b0000, 1'b0);
      tick_edge(4'b0001);
      chk("os_e1", 0, 2, 4'b0000, 4'b0000, 1'b0);
      tick_edge(4'b0001);
      chk("os_e2", 0, 1, 4'b0000, 4'b0000, 1'b0);
      tick_edge(4'b0001);
      chk("os_e3", 0, 0, 4'b0001, 4'b0001, 1'b1);
      chk("os_hold", 0, 0, 4'b0001, 4'b0001, 1'b1);
      tick_edge(4'b0001);
      chk("os_e4", 0, 0, 4'b0001, 4'b0001, 1'b1);
      bus_wr(0, 1'b0, 2);
      tick_edge(4'b0001);
      chk("os_en_clr", 0, 2, 4'b0000, 4'b0001, 1'b1);
      bus_wr(0, 1'b1, 32'h10);
      chk("os_clr", 0, 2, 4'b0000, 4'b0000, 1'b0);

      // Periodic on ch1, reload 2, IE off
      do_reset();
      bus_wr(1, 1'b0, 2);
      bus_wr(1, 1'b1, 32'h03);
      for (int k = 1; k <= 6; k++) begin
         tick_edge(4'b0010);
         if (k % 2 == 0) begin
            chk($sformatf("per_e%0d", k), 1, 2, 4'b0010, 4'b0010, 1'b0);
            chk($sformatf("per_e%0d_fall", k), 1, 2, 4'b0000, 4'b0010, 1'b0);
         end else begin
            chk($sformatf("per_e%0d", k), 1, 1, 4'b0000, (k == 1) ? 4'b0000 : 4'b0010, 1'b0);
         end
      end

      // Square wave on ch2, reload 4
      do_reset();
      bus_wr(2, 1'b0, 4);
      bus_wr(2, 1'b1, 32'h05);
      for (int k = 1; k <= 18; k++) begin
         tick_edge(4'b0100);
         chk($sformatf("sq_e%0d", k), 2, (k % 4 == 0) ? 4 : 4 - (k % 4),
             ((k / 4) % 2 == 1) ? 4'b0100 : 4'b0000, (k >= 4) ? 4'b0100 : 4'b0000, 1'b0);
      end
      bus_wr(2, 1'b0, 0);
      for (int k = 1; k <= 3; k++) begin
         tick_edge(4'b0100);
         chk($sformatf("sq_frozen%0d", k), 2, 0, 4'b0000, 4'b0100, 1'b0);
      end

      // Free-run up on ch3 across the wrap
      do_reset();
      bus_wr(3, 1'b0, 32'hFFFF_FFFE);
      bus_wr(3, 1'b1, 32'h0F);
      chk("fr_load", 3, 32'hFFFF_FFFE, 4'b0000, 4'b0000, 1'b0);
      tick_edge(4'b1000);
      chk("fr_e1", 3, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 1'b0);
      tick_edge(4'b1000);
      chk("fr_wrap", 3, 0, 4'b1000, 4'b1000, 1'b1);
      chk("fr_wrap_fall", 3, 0, 4'b0000, 4'b1000, 1'b1);
      tick_edge(4'b1000);
      chk("fr_e3", 3, 1, 4'b0000, 4'b1000, 1'b1);

      // Write vs edge collision on ch1
      do_reset();
      bus_wr(1, 1'b0, 5);
      bus_wr(1, 1'b1, 32'h03);
      tick_edge(4'b0010);
      chk("col_pre", 1, 4, 4'b0000, 4'b0000, 1'b0);
      bus_wr_edge(1, 1'b0, 9, 4'b0010);
      chk("col_wr_wins", 1, 9, 4'b0000, 4'b0000, 1'b0);
      chk("col_rd5", 5, 0, 4'b0000, 4'b0000, 1'b0);
      tick_edge(4'b0010);
      chk("col_next", 1, 8, 4'b0000, 4'b0000, 1'b0);

      // CLR in the same clk as a one-shot terminal event on ch0
      bus_wr(0, 1'b0, 1);
      bus_wr(0, 1'b1, 32'h09);
      bus_wr_edge(0, 1'b1, 32'h19, 4'b0001);
      chk("clr_vs_set", 0, 0, 4'b0001, 4'b0001, 1'b1);
      chk("ch1_undisturbed", 1, 8, 4'b0001, 4'b0001, 1'b1);

      // Reset mid-count with ticks rising
      rst  = 1'b1;
      tick = 4'b1111;
      @(posedge clk); #1;
      rst  = 1'b0;
      tick = 4'b0000;
      for (int c = 0; c < NCH; c++) chk($sformatf("midrst_ch%0d", c), c, 0, 4'b0000, 4'b0000, 1'b0);
      tick_edge(4'b0010);
      chk("midrst_idle", 1, 0, 4'b0000, 4'b0000, 1'b0);

      repeat (2) @(posedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
